byte_mem_arbiter: RTL and testbench
===================================

Name: byte_mem_arbiter

Overview:
- Memory controller between the CPU pipeline and the external 8-bit RAM/IO bus (mem_din/mem_dout/mem_a/mem_wr).
- Arbitrates the instruction-fetch port (IF) and the load/store port (LS), with LS winning.
- Serialises each 1/2/4-byte access into byte cycles, assembles read words little-endian, and returns one registered done pulse per transaction.

Parameters:
ADDR_W, 32, address width on all address ports

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
rdy  in  1  pause; when low the block freezes
if_req  in  1  fetch request, held until if_done
if_addr  in  ADDR_W  fetch address
if_clear  in  1  abort the in-flight fetch (branch taken)
if_done  out  1  one-cycle pulse; if_inst valid in that cycle
if_inst  out  32  fetched word
ls_req  in  1  load/store request, held until ls_done
ls_we  in  1  1 = store
ls_size  in  2  00 byte, 01 half, 10/11 word
ls_addr  in  ADDR_W  data address
ls_wdata  in  32  store data, low bytes used
ls_done  out  1  one-cycle pulse
ls_rdata  out  32  load data, zero-extended
mem_din  in  8  RAM read byte; valid one cycle after its address is presented
mem_dout  out  8  RAM write byte
mem_a  out  ADDR_W  RAM address
mem_wr  out  1  1 = write

Behaviour:
- Reset values: all outputs are 0. State returns to IDLE. The byte counter and assembly register clear.
- Reset mid-transaction: the transaction is discarded with no done pulse. mem_wr goes low from the next cycle.
- States are IDLE, RD, WR and DONE. N is the byte count of the accepted request: 1, 2 or 4 (IF is always 4).
- IDLE, at an edge with rdy=1:
  - If ls_req=1, accept the LS request.
  - Otherwise, if if_req=1 and if_clear=0, accept the IF request.
  - The source is latched; address, size and wdata are captured at acceptance.
- Read, accepted at edge E0:
  - After E0: state RD, mem_a=A, count=0.
  - At edge Ek (k=1..N): capture mem_din into byte k-1 of the assembly register.
  - After Ek: if k<N, mem_a=A+k. At EN, state goes to DONE and mem_a=0.
  - The matching done output and its data are valid in the cycle after EN, i.e. N edges after acceptance.
  - No address outside A..A+N-1 is ever presented while RD, so there are no speculative reads of the IO region (addr[17:16]=11).
- Write, accepted at edge E0:
  - After Ek (k=0..N-1): mem_wr=1, mem_a=A+k, mem_dout=wdata byte k.
  - At EN: mem_wr=0, mem_a=0, state DONE.
  - Exactly N write cycles occur.
- DONE:
  - The matching done output is high for exactly one cycle.
  - No request is accepted at the edge ending DONE, so requesters may drop req on seeing done.
  - The next edge returns to IDLE. A new transaction can therefore be accepted at the edge that ends the first IDLE cycle after DONE.
- ls_rdata/if_inst: hold their value after done until the next completion of the same port. Unused upper bytes are 0.
- Arithmetic: address increments are ADDR_W-bit modulo, so A=FFFF_FFFF wraps to 0.
- if_clear:
  - Sampled high during an IF RD cycle: at that edge go to IDLE, mem_a=0, no if_done, partial data discarded.
  - If_clear has no effect on LS transactions.
  - In IDLE it blocks IF acceptance that cycle.
- rdy=0:
  - All registers hold: state, counter, address, data and done.
  - mem_wr is gated to 0 combinationally; mem_wr = wr_reg AND rdy, the only combinational output.
  - The held byte (write) or held address (read) is re-issued when rdy returns.
  - No mem_din capture occurs on paused edges.
- Simultaneous ls_req and if_req in IDLE: LS is served first. IF is accepted at the first IDLE edge afterwards if if_req is still high.
- A request that deasserts before acceptance is never served.

Test Plan:
1. Fetch, if_addr=0x4, RAM[4..7]=13 05 00 00: mem_a 4,5,6,7 over consecutive cycles; if_done pulses 4 edges after acceptance; if_inst=0x00000513.
2. if_req and ls_req (load byte at 0x100, RAM=0x8F) raised in the same cycle: ls_done first with ls_rdata=0x0000008F, then if_done; mem_a never shows an IF address before ls_done.
3. Store half 0xBEEF at 0x200: mem_wr high exactly 2 cycles, (0x200,EF) then (0x201,BE); ls_done the cycle after; mem_wr=0 and mem_a=0 afterwards.
4. Word load from 0x300 (11 22 33 44) with rdy low for 3 cycles after the 2nd byte: no state change while paused; ls_rdata=0x44332211; done delayed by exactly 3 cycles.
5. if_clear pulsed 2 edges into a fetch: no if_done; a new fetch at 0x40 is accepted the following IDLE edge and completes normally.
6. rst asserted mid word-store after 2 bytes: mem_wr=0 and outputs 0 next cycle, no ls_done; a subsequent load is served correctly.

Source files
------------

// File: rtl/byte_mem_arbiter.sv
// Byte-serial memory controller: arbitrates instruction fetch and load/store
// onto an 8-bit RAM/IO bus, assembling little-endian words and pulsing done.
module byte_mem_arbiter #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              if_clear,
    output logic              if_done,
    output logic [31:0]       if_inst,
    input  logic              ls_req,
    input  logic              ls_we,
    input  logic [1:0]        ls_size,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic [31:0]       ls_wdata,
    output logic              ls_done,
    output logic [31:0]       ls_rdata,
    input  logic [7:0]        mem_din,
    output logic [7:0]        mem_dout,
    output logic [ADDR_W-1:0] mem_a,
    output logic              mem_wr
);

    typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

    state_t              state_q, state_d;
    logic                src_ls_q, src_ls_d;
    logic [2:0]          n_q, n_d;
    logic [1:0]          cnt_q, cnt_d;
    logic [ADDR_W-1:0]   base_q, base_d;
    logic [31:0]         wdata_q, wdata_d;
    logic [31:0]         asm_q, asm_d;
    logic [ADDR_W-1:0]   mem_a_q, mem_a_d;
    logic [7:0]          mem_dout_q, mem_dout_d;
    logic                wr_q, wr_d;
    logic                if_done_q, if_done_d;
    logic                ls_done_q, ls_done_d;
    logic [31:0]         if_inst_q, if_inst_d;
    logic [31:0]         ls_rdata_q, ls_rdata_d;

    logic [2:0]          cnt_nx;
    logic                last;
    logic [ADDR_W-1:0]   addr_nx;
    logic [31:0]         asm_word;
    logic [7:0]          wbyte;
    logic [2:0]          ls_n;

    assign cnt_nx  = {1'b0, cnt_q} + 3'd1;
    assign last    = (cnt_nx == n_q);
    assign addr_nx = base_q + ADDR_W'(cnt_nx);

    // Assembly word with the byte arriving this cycle merged into its lane.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign asm_word[gi*8 +: 8] = (cnt_q == 2'(gi)) ? mem_din : asm_q[gi*8 +: 8];
        end
    endgenerate

    always_comb begin
        wbyte = wdata_q[7:0];
        case (cnt_nx[1:0])
            2'd1:    wbyte = wdata_q[15:8];
            2'd2:    wbyte = wdata_q[23:16];
            2'd3:    wbyte = wdata_q[31:24];
            default: wbyte = wdata_q[7:0];
        endcase
    end

    always_comb begin
        case (ls_size)
            2'b00:   ls_n = 3'd1;
            2'b01:   ls_n = 3'd2;
            default: ls_n = 3'd4;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        src_ls_d   = src_ls_q;
        n_d        = n_q;
        cnt_d      = cnt_q;
        base_d     = base_q;
        wdata_d    = wdata_q;
        asm_d      = asm_q;
        mem_a_d    = mem_a_q;
        mem_dout_d = mem_dout_q;
        wr_d       = wr_q;
        if_done_d  = if_done_q;
        ls_done_d  = ls_done_q;
        if_inst_d  = if_inst_q;
        ls_rdata_d = ls_rdata_q;
        // A paused cycle leaves every register, including the done pulses, untouched.
        if (rdy) begin
            if_done_d = 1'b0;
            ls_done_d = 1'b0;
            case (state_q)
                IDLE: begin
                    if (ls_req) begin
                        src_ls_d = 1'b1;
                        base_d   = ls_addr;
                        n_d      = ls_n;
                        wdata_d  = ls_wdata;
                        cnt_d    = 2'd0;
                        asm_d    = 32'd0;
                        mem_a_d  = ls_addr;
                        if (ls_we) begin
                            state_d    = WR;
                            wr_d       = 1'b1;
                            mem_dout_d = ls_wdata[7:0];
                        end else begin
                            state_d = RD;
                        end
                    end else if (if_req && !if_clear) begin
                        src_ls_d = 1'b0;
                        base_d   = if_addr;
                        n_d      = 3'd4;
                        cnt_d    = 2'd0;
                        asm_d    = 32'd0;
                        mem_a_d  = if_addr;
                        state_d  = RD;
                    end
                end
                RD: begin
                    if (!src_ls_q && if_clear) begin
                        state_d = IDLE;
                        mem_a_d = '0;
                        cnt_d   = 2'd0;
                        asm_d   = 32'd0;
                    end else if (last) begin
                        state_d = DONE;
                        mem_a_d = '0;
                        asm_d   = asm_word;
                        if (src_ls_q) begin
                            ls_done_d  = 1'b1;
                            ls_rdata_d = asm_word;
                        end else begin
                            if_done_d = 1'b1;
                            if_inst_d = asm_word;
                        end
                    end else begin
                        asm_d   = asm_word;
                        cnt_d   = cnt_nx[1:0];
                        mem_a_d = addr_nx;
                    end
                end
                WR: begin
                    if (last) begin
                        state_d    = DONE;
                        wr_d       = 1'b0;
                        mem_a_d    = '0;
                        mem_dout_d = 8'd0;
                        ls_done_d  = 1'b1;
                    end else begin
                        cnt_d      = cnt_nx[1:0];
                        mem_a_d    = addr_nx;
                        mem_dout_d = wbyte;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            src_ls_q   <= 1'b0;
            n_q        <= 3'd0;
            cnt_q      <= 2'd0;
            base_q     <= '0;
            wdata_q    <= 32'd0;
            asm_q      <= 32'd0;
            mem_a_q    <= '0;
            mem_dout_q <= 8'd0;
            wr_q       <= 1'b0;
            if_done_q  <= 1'b0;
            ls_done_q  <= 1'b0;
            if_inst_q  <= 32'd0;
            ls_rdata_q <= 32'd0;
        end else begin
            state_q    <= state_d;
            src_ls_q   <= src_ls_d;
            n_q        <= n_d;
            cnt_q      <= cnt_d;
            base_q     <= base_d;
            wdata_q    <= wdata_d;
            asm_q      <= asm_d;
            mem_a_q    <= mem_a_d;
            mem_dout_q <= mem_dout_d;
            wr_q       <= wr_d;
            if_done_q  <= if_done_d;
            ls_done_q  <= ls_done_d;
            if_inst_q  <= if_inst_d;
            ls_rdata_q <= ls_rdata_d;
        end
    end

    // The write strobe is dropped immediately on a pause so no byte is written twice.
    assign mem_wr   = wr_q & rdy;
    assign mem_a    = mem_a_q;
    assign mem_dout = mem_dout_q;
    assign if_done  = if_done_q;
    assign ls_done  = ls_done_q;
    assign if_inst  = if_inst_q;
    assign ls_rdata = ls_rdata_q;

endmodule

// File: tb/tb_byte_mem_arbiter.sv
// Directed bench for byte_mem_arbiter: RAM model answers combinationally from
// mem_a, writes are logged per address, and each step checks hand-derived values.
module tb_byte_mem_arbiter;
    localparam int ADDR_W = 32;

    logic              clk = 1'b0;
    logic              rst, rdy;
    logic              if_req, if_clear, if_done;
    logic [ADDR_W-1:0] if_addr;
    logic [31:0]       if_inst;
    logic              ls_req, ls_we, ls_done;
    logic [1:0]        ls_size;
    logic [ADDR_W-1:0] ls_addr;
    logic [31:0]       ls_wdata, ls_rdata;
    logic [7:0]        mem_din, mem_dout;
    logic [ADDR_W-1:0] mem_a;
    logic              mem_wr;

    logic [7:0] ram    [0:1023];
    logic [7:0] wr_log [0:1023];
    int         wr_cnt = 0;
    int         n_cmp  = 0;
    int         n_err  = 0;
    int         wbase;

    always #5 clk = ~clk;

    byte_mem_arbiter #(.ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .if_req(if_req), .if_addr(if_addr), .if_clear(if_clear),
        .if_done(if_done), .if_inst(if_inst),
        .ls_req(ls_req), .ls_we(ls_we), .ls_size(ls_size), .ls_addr(ls_addr),
        .ls_wdata(ls_wdata), .ls_done(ls_done), .ls_rdata(ls_rdata),
        .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr)
    );

    assign mem_din = ram[mem_a[9:0]];

    always @(posedge clk) begin
        if (mem_wr) begin
            wr_log[mem_a[9:0]] <= mem_dout;
            wr_cnt <= wr_cnt + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) ram[i] = 8'h00;
        ram[4] = 8'h13; ram[5] = 8'h05; ram[6] = 8'h00; ram[7] = 8'h00;
        ram[8] = 8'h93; ram[9] = 8'h00; ram[10] = 8'h10; ram[11] = 8'h00;
        ram[12'h100] = 8'h8F;
        ram[12'h300] = 8'h11; ram[12'h301] = 8'h22; ram[12'h302] = 8'h33; ram[12'h303] = 8'h44;
        ram[12'h040] = 8'h13; ram[12'h041] = 8'h01; ram[12'h042] = 8'h01; ram[12'h043] = 8'hFF;
        ram[12'h3FF] = 8'h5A;
        ram[0] = 8'hC3;

        rst = 1'b1; rdy = 1'b1;
        if_req = 1'b0; if_addr = '0; if_clear = 1'b0;
        ls_req = 1'b0; ls_we = 1'b0; ls_size = 2'b00; ls_addr = '0; ls_wdata = 32'd0;
        tick(); tick();
        rst = 1'b0;
        chk("rst if_done", if_done, 0);
        chk("rst if_inst", if_inst, 0);
        chk("rst ls_done", ls_done, 0);
        chk("rst ls_rdata", ls_rdata, 0);
        chk("rst mem_a", mem_a, 0);
        chk("rst mem_dout", mem_dout, 0);
        chk("rst mem_wr", mem_wr, 0);

        // Fetch of four bytes at 0x4
        if_req = 1'b1; if_addr = 32'h4;
        tick(); chk("f1 a0", mem_a, 32'h4);
        tick(); chk("f1 a1", mem_a, 32'h5); chk("f1 nodone", if_done, 0);
        tick(); chk("f1 a2", mem_a, 32'h6);
        tick(); chk("f1 a3", mem_a, 32'h7); chk("f1 nodone3", if_done, 0);
        tick(); chk("f1 done", if_done, 1); chk("f1 inst", if_inst, 32'h00000513); chk("f1 a_idle", mem_a, 0);
        if_req = 1'b0;
        tick(); chk("f1 pulse", if_done, 0); chk("f1 hold", if_inst, 32'h00000513);
        $display("txn fetch 0x4 inst=%h", if_inst);

        // Simultaneous requests: LS byte load wins
        if_req = 1'b1; if_addr = 32'h8;
        ls_req = 1'b1; ls_we = 1'b0; ls_size = 2'b00; ls_addr = 32'h100;
        tick(); chk("arb a_ls", mem_a, 32'h100);
        tick(); chk("arb ls_done", ls_done, 1); chk("arb rdata", ls_rdata, 32'h0000008F);
        chk("arb if_idle", if_done, 0);
        ls_req = 1'b0;
        tick(); chk("arb done_edge", mem_a, 0); chk("arb ls_pulse", ls_done, 0);
        $display("txn load byte 0x100 rdata=%h", ls_rdata);
        tick(); chk("arb if_a0", mem_a, 32'h8);
        tick(); tick(); tick();
        chk("arb if_pending", if_done, 0);
        tick(); chk("arb if_done", if_done, 1); chk("arb if_inst", if_inst, 32'h00100093);
        chk("arb ls_hold", ls_rdata, 32'h0000008F);
        if_req = 1'b0;
        tick();
        $display("txn fetch 0x8 inst=%h", if_inst);

        // Half store 0xBEEF at 0x200
        wbase = wr_cnt;
        ls_req = 1'b1; ls_we = 1'b1; ls_size = 2'b01; ls_addr = 32'h200; ls_wdata = 32'h1234BEEF;
        tick(); chk("st wr0", mem_wr, 1); chk("st a0", mem_a, 32'h200); chk("st d0", mem_dout, 8'hEF);
        tick(); chk("st wr1", mem_wr, 1); chk("st a1", mem_a, 32'h201); chk("st d1", mem_dout, 8'hBE);
        tick(); chk("st wr_off", mem_wr, 0); chk("st a_off", mem_a, 0); chk("st done", ls_done, 1);
        chk("st count", 32'(wr_cnt - wbase), 2);
        chk("st byte0", wr_log[12'h200], 8'hEF); chk("st byte1", wr_log[12'h201], 8'hBE);
        ls_req = 1'b0;
        tick(); chk("st pulse", ls_done, 0);
        $display("txn store half 0x200 writes=%0d", wr_cnt - wbase);

        // Word load at 0x300 paused for three cycles after the 2nd byte
        ls_req = 1'b1; ls_we = 1'b0; ls_size = 2'b10; ls_addr = 32'h300;
        tick(); chk("ld a0", mem_a, 32'h300);
        tick(); chk("ld a1", mem_a, 32'h301);
        tick(); chk("ld a2", mem_a, 32'h302);
        rdy = 1'b0;
        tick(); chk("ld p1 a", mem_a, 32'h302); chk("ld p1 done", ls_done, 0);
        tick(); chk("ld p2 a", mem_a, 32'h302);
        tick(); chk("ld p3 a", mem_a, 32'h302); chk("ld p3 done", ls_done, 0);
        rdy = 1'b1;
        tick(); chk("ld a3", mem_a, 32'h303); chk("ld predone", ls_done, 0);
        tick(); chk("ld done", ls_done, 1); chk("ld rdata", ls_rdata, 32'h44332211);
        ls_req = 1'b0;
        tick();
        $display("txn load word 0x300 rdata=%h", ls_rdata);

        // Byte store paused: mem_wr gated, no extra write
        wbase = wr_cnt;
        ls_req = 1'b1; ls_we = 1'b1; ls_size = 2'b00; ls_addr = 32'h210; ls_wdata = 32'h000000A5;
        tick(); chk("sp wr", mem_wr, 1);
        rdy = 1'b0; #1; chk("sp gated", mem_wr, 0);
        tick(); chk("sp hold_a", mem_a, 32'h210); chk("sp nowrite", 32'(wr_cnt - wbase), 0);
        rdy = 1'b1; #1; chk("sp regate", mem_wr, 1);
        tick(); chk("sp done", ls_done, 1); chk("sp byte", wr_log[12'h210], 8'hA5);
        chk("sp count", 32'(wr_cnt - wbase), 1);
        ls_req = 1'b0;
        tick();
        $display("txn store byte 0x210 (paused) writes=%0d", wr_cnt - wbase);

        // Fetch aborted by if_clear, then fetch at 0x40
        if_req = 1'b1; if_addr = 32'h10;
        tick(); chk("clr a0", mem_a, 32'h10);
        tick(); chk("clr a1", mem_a, 32'h11);
        if_clear = 1'b1;
        tick(); chk("clr a_idle", mem_a, 0); chk("clr nodone", if_done, 0);
        if_clear = 1'b0; if_addr = 32'h40;
        tick(); chk("clr new_a0", mem_a, 32'h40); chk("clr nodone2", if_done, 0);
        tick(); chk("clr new_a1", mem_a, 32'h41);
        tick(); chk("clr new_a2", mem_a, 32'h42);
        tick(); chk("clr new_a3", mem_a, 32'h43);
        tick(); chk("clr done", if_done, 1); chk("clr inst", if_inst, 32'hFF010113);
        if_req = 1'b0;
        tick();
        $display("txn fetch 0x40 after clear inst=%h", if_inst);

        // Reset in the middle of a word store
        ls_req = 1'b1; ls_we = 1'b1; ls_size = 2'b11; ls_addr = 32'h220; ls_wdata = 32'hDDCCBBAA;
        tick(); chk("rs a0", mem_a, 32'h220); chk("rs d0", mem_dout, 8'hAA);
        tick(); chk("rs a1", mem_a, 32'h221); chk("rs d1", mem_dout, 8'hBB);
        rst = 1'b1;
        tick(); chk("rs wr", mem_wr, 0); chk("rs a", mem_a, 0); chk("rs dout", mem_dout, 0);
        chk("rs done", ls_done, 0); chk("rs rdata", ls_rdata, 0); chk("rs inst", if_inst, 0);
        rst = 1'b0; ls_req = 1'b0;
        wbase = wr_cnt;
        tick(); chk("rs quiet", ls_done, 0); chk("rs nowrite", 32'(wr_cnt - wbase), 0);
        ram[12'h220] = 8'hAA; ram[12'h221] = 8'hBB;
        ls_req = 1'b1; ls_we = 1'b0; ls_size = 2'b01; ls_addr = 32'h220;
        tick(); chk("rs ld a0", mem_a, 32'h220);
        tick(); chk("rs ld a1", mem_a, 32'h221);
        tick(); chk("rs ld done", ls_done, 1); chk("rs ld rdata", ls_rdata, 32'h0000BBAA);
        ls_req = 1'b0;
        tick();
        $display("txn reset mid-store, then load half 0x220 rdata=%h", ls_rdata);

        // Half load at the top of the address space wraps to 0
        ls_req = 1'b1; ls_we = 1'b0; ls_size = 2'b01; ls_addr = 32'hFFFFFFFF;
        tick(); chk("wrap a0", mem_a, 32'hFFFFFFFF);
        tick(); chk("wrap a1", mem_a, 32'h0);
        tick(); chk("wrap done", ls_done, 1); chk("wrap rdata", ls_rdata, 32'h0000C35A);
        ls_req = 1'b0;
        tick();
        $display("txn load half 0xFFFFFFFF rdata=%h", ls_rdata);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
